// File: rtl/program_loader.sv
// Byte-stream loader: 4-byte LE word count, then N LE words written to imem at 0..N-1; optional XOR checksum under LOADER_CHECKSUM_EN.
// One word per 5 cycles at full rate; inReady only in LEN/DATA/CHK, byte assembly stalls while inValid is low.
module program_loader #(
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        inValid,
   input  logic [7:0]  inByte,
   output logic        inReady,
   output logic        imemWe,
   output logic [31:0] imemAddr,
   output logic [31:0] imemData,
   output logic        coreHold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      WRITE,
`ifdef LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] word_q, word_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] asm_word;
   logic        accept;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  chk_q, chk_d;
   localparam state_t END_STATE = CHK;
`else
   localparam state_t END_STATE = DONE;
`endif

   assign accept   = inValid & inReady;
   // Length and data words share one little-endian shift register.
   assign asm_word = {inByte, word_q[31:8]};

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
`ifdef LOADER_CHECKSUM_EN
      chk_d      = chk_q;
`endif
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d    = LEN;
               byte_cnt_d = 2'd0;
               addr_d     = 32'd0;
`ifdef LOADER_CHECKSUM_EN
               chk_d      = 8'd0;
`endif
            end
         end
         LEN: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               word_d     = asm_word;
               if (byte_cnt_q == 2'd3) begin
                  cnt_d = asm_word;
                  if (asm_word > 32'(DEPTH))
                     state_d = ERR;
                  else if (asm_word == 32'd0)
                     state_d = END_STATE;
                  else
                     state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               word_d     = asm_word;
`ifdef LOADER_CHECKSUM_EN
               chk_d      = chk_q ^ inByte;
`endif
               if (byte_cnt_q == 2'd3)
                  state_d = WRITE;
            end
         end
         WRITE: begin
            cnt_d   = cnt_q - 32'd1;
            addr_d  = addr_q + 32'd1;
            state_d = (cnt_q == 32'd1) ? END_STATE : DATA;
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: begin
            if (accept)
               state_d = (inByte == chk_q) ? DONE : ERR;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         byte_cnt_q <= 2'd0;
         word_q     <= 32'd0;
         cnt_q      <= 32'd0;
         addr_q     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         chk_q      <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
`ifdef LOADER_CHECKSUM_EN
         chk_q      <= chk_d;
`endif
      end
   end

`ifdef LOADER_CHECKSUM_EN
   assign inReady = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
   assign busy    = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE) || (state_q == CHK);
`else
   assign inReady = (state_q == LEN) || (state_q == DATA);
   assign busy    = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE);
`endif
   assign imemWe   = (state_q == WRITE);
   assign imemAddr = addr_q;
   assign imemData = word_q;
   assign done     = (state_q == DONE);
   assign error    = (state_q == ERR);
   assign coreHold = (state_q != DONE);

endmodule
